// File: rtl/instruction_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package instruction_fetch_pkg;

  localparam int ISA_WIDTH           = 32;
  localparam int IMEM_ADDR_WIDTH_DEF = 14;

  typedef enum logic [1:0] {
    IF_FETCH_REQ  = 2'd0,
    IF_FETCH_WAIT = 2'd1,
    IF_EXEC       = 2'd2
  } if_state_t;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JR     = 2'd3
  } next_pc_sel_t;

  // jr beats jmp/jal, which beat a taken branch.
  function automatic next_pc_sel_t select_next_pc(input logic jr,
                                                  input logic jmp,
                                                  input logic jal,
                                                  input logic branch_taken);
    if (jr)
      return NPC_JR;
    else if (jmp || jal)
      return NPC_JUMP;
    else if (branch_taken)
      return NPC_BRANCH;
    else
      return NPC_SEQ;
  endfunction

endpackage

// File: rtl/instruction_fetch_next_pc_calc.sv
// Combinational next-PC selection from the resolved control-flow inputs.
module next_pc_calc
  import instruction_fetch_pkg::*;
(
  input  logic [ISA_WIDTH-1:0] opcplus4,
  input  logic [25:0]          instr_index,
  input  logic [ISA_WIDTH-1:0] imm_ext,
  input  logic [ISA_WIDTH-1:0] reg_rs,
  input  logic                 branch_taken,
  input  logic                 jmp,
  input  logic                 jal,
  input  logic                 jr,
  output logic [ISA_WIDTH-1:0] next_pc
);

  next_pc_sel_t sel;

  always_comb begin
    sel     = select_next_pc(jr, jmp, jal, branch_taken);
    next_pc = opcplus4;
    unique case (sel)
      NPC_JR:     next_pc = reg_rs & ~ISA_WIDTH'(3);
      NPC_JUMP:   next_pc = {opcplus4[31:28], instr_index, 2'b00};
      // A full 32-bit left shift equals {imm_ext[29:0],2'b00}.
      NPC_BRANCH: next_pc = opcplus4 + (imm_ext << 2);
      default:    next_pc = opcplus4;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, fetches from the instruction ROM over req/ack,
// holds each instruction for one EXEC cycle, then steps to the next PC.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [ISA_WIDTH-1:0] RESET_PC        = 32'h0000_0000,
  parameter int                   IMEM_ADDR_WIDTH = IMEM_ADDR_WIDTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       branch_taken,
  input  logic                       jmp,
  input  logic                       jal,
  input  logic                       jr,
  input  logic [ISA_WIDTH-1:0]       imm_ext,
  input  logic [ISA_WIDTH-1:0]       reg_rs,
  input  logic                       stall,
  output logic                       imem_req,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [ISA_WIDTH-1:0]       imem_rdata,
  input  logic                       imem_ack,
  output logic [ISA_WIDTH-1:0]       Instruction,
  output logic [ISA_WIDTH-1:0]       opcplus4,
  output logic [ISA_WIDTH-1:0]       pc,
  output logic                       instr_valid
);

  if_state_t            state;
  logic [ISA_WIDTH-1:0] next_pc;

  assign imem_addr = pc[IMEM_ADDR_WIDTH+1:2];

  next_pc_calc u_next_pc_calc (
    .opcplus4     (opcplus4),
    .instr_index  (Instruction[25:0]),
    .imm_ext      (imm_ext),
    .reg_rs       (reg_rs),
    .branch_taken (branch_taken),
    .jmp          (jmp),
    .jal          (jal),
    .jr           (jr),
    .next_pc      (next_pc)
  );

  // imem_req is raised on entry to FETCH_REQ so it is visible during that
  // cycle; after reset one arming cycle raises it before leaving FETCH_REQ.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IF_FETCH_REQ;
      pc          <= RESET_PC;
      Instruction <= '0;
      opcplus4    <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      unique case (state)
        IF_FETCH_REQ: begin
          if (imem_req) begin
            imem_req <= 1'b0;
            state    <= IF_FETCH_WAIT;
          end else begin
            imem_req <= 1'b1;
          end
        end
        IF_FETCH_WAIT: begin
          if (imem_ack) begin
            Instruction <= imem_rdata;
            opcplus4    <= pc + ISA_WIDTH'(4);
            instr_valid <= 1'b1;
            state       <= IF_EXEC;
          end
        end
        IF_EXEC: begin
          if (!stall) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= IF_FETCH_REQ;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IF_FETCH_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a variable-latency ROM responder.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jmp = 1'b0;
  logic        jal = 1'b0;
  logic        jr = 1'b0;
  logic [31:0] imm_ext = '0;
  logic [31:0] reg_rs = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] Instruction;
  logic [31:0] opcplus4;
  logic [31:0] pc;
  logic        instr_valid;

  int          passed = 0;
  int          total = 0;
  int          lat = 1;
  int          pend;
  logic [31:0] rom_data;
  logic        force_ack = 1'b0;
  int          reqs;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_WIDTH(14)) dut (
    .clock        (clock),
    .reset        (reset),
    .branch_taken (branch_taken),
    .jmp          (jmp),
    .jal          (jal),
    .jr           (jr),
    .imm_ext      (imm_ext),
    .reg_rs       (reg_rs),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .Instruction  (Instruction),
    .opcplus4     (opcplus4),
    .pc           (pc),
    .instr_valid  (instr_valid)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [13:0] a);
    case (a)
      14'd2:   return 32'h0C00_0040;
      14'd8:   return 32'h0800_0010;
      default: return 32'hA500_0000 | {18'd0, a};
    endcase
  endfunction

  // ROM: data appears `lat` cycles after the req cycle; force_ack injects a stray strobe.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend     <= 0;
      rom_data <= '0;
    end else if (imem_req) begin
      pend     <= lat;
      rom_data <= rom_word(imem_addr);
    end else if (pend != 0) begin
      pend <= pend - 1;
    end
  end

  assign imem_ack   = (pend == 1) || force_ack;
  assign imem_rdata = force_ack ? 32'hDEAD_BEEF : rom_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_ctl();
    branch_taken = 1'b0;
    jmp          = 1'b0;
    jal          = 1'b0;
    jr           = 1'b0;
    stall        = 1'b0;
    imm_ext      = '0;
    reg_rs       = '0;
  endtask

  task automatic wait_exec(output int n_req);
    bit done;
    done  = 1'b0;
    n_req = 0;
    for (int i = 0; i < 40; i++) begin
      if (!done) begin
        step();
        if (imem_req === 1'b1) n_req++;
        if (instr_valid === 1'b1) done = 1'b1;
      end
    end
  endtask

  // Called in EXEC with controls already applied.
  task automatic advance(input logic [31:0] exp_pc, input string tag);
    int r;
    step();
    chk({tag, "/pc"}, pc, exp_pc);
    chk({tag, "/req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, "/addr"}, {18'd0, imem_addr}, {18'd0, exp_pc[15:2]});
    clear_ctl();
    wait_exec(r);
    chk({tag, "/valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "/extra_req"}, r, 32'd0);
    chk({tag, "/instr"}, Instruction, rom_word(exp_pc[15:2]));
    chk({tag, "/opc4"}, opcplus4, exp_pc + 32'd4);
  endtask

  initial begin
    step();
    step();
    chk("rst/pc", pc, 32'h0);
    chk("rst/instr", Instruction, 32'h0);
    chk("rst/opc4", opcplus4, 32'h0);
    chk("rst/valid", {31'd0, instr_valid}, 32'd0);
    chk("rst/req", {31'd0, imem_req}, 32'd0);

    reset = 1'b1;
    step();
    chk("first/req", {31'd0, imem_req}, 32'd1);
    chk("first/addr", {18'd0, imem_addr}, 32'd0);
    step();
    chk("first/req_drop", {31'd0, imem_req}, 32'd0);
    chk("first/valid_lo", {31'd0, instr_valid}, 32'd0);
    step();
    chk("first/valid", {31'd0, instr_valid}, 32'd1);
    chk("first/instr", Instruction, 32'hA500_0000);
    chk("first/pc", pc, 32'h0);
    chk("first/opc4", opcplus4, 32'h4);

    // Stray acks in EXEC and FETCH_REQ, then latency-3 fetch.
    force_ack = 1'b1;
    lat = 3;
    step();
    chk("seq4/pc", pc, 32'h4);
    chk("seq4/req", {31'd0, imem_req}, 32'd1);
    step();
    force_ack = 1'b0;
    chk("seq4/wait_req", {31'd0, imem_req}, 32'd0);
    chk("seq4/wait_valid", {31'd0, instr_valid}, 32'd0);
    chk("seq4/addr", {18'd0, imem_addr}, 32'd1);
    wait_exec(reqs);
    chk("seq4/valid", {31'd0, instr_valid}, 32'd1);
    chk("seq4/extra_req", reqs, 32'd0);
    chk("seq4/instr", Instruction, 32'hA500_0001);
    chk("seq4/opc4", opcplus4, 32'h8);

    advance(32'h8, "seq8");

    lat = 1;
    jal = 1'b1;
    advance(32'h100, "jal");

    jr = 1'b1; branch_taken = 1'b1; reg_rs = 32'h123; imm_ext = 32'h5;
    advance(32'h120, "jr_br");

    jr = 1'b1; reg_rs = 32'h13;
    advance(32'h10, "jr");

    branch_taken = 1'b1; imm_ext = 32'hFFFF_FFFF;
    advance(32'h10, "br_back");

    branch_taken = 1'b1; imm_ext = 32'h3;
    advance(32'h20, "br_fwd");

    // Stall with a jump pending: everything holds, no fetch.
    stall = 1'b1;
    jmp = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall/valid", {31'd0, instr_valid}, 32'd1);
      chk("stall/pc", pc, 32'h20);
      chk("stall/instr", Instruction, 32'h0800_0010);
      chk("stall/req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    lat = 5;
    step();
    chk("jmp/pc", pc, 32'h40);
    chk("jmp/req", {31'd0, imem_req}, 32'd1);
    clear_ctl();
    step();
    chk("wait40/req", {31'd0, imem_req}, 32'd0);
    chk("wait40/addr", {18'd0, imem_addr}, 32'h10);

    // Asynchronous reset in the middle of FETCH_WAIT.
    reset = 1'b0;
    #1;
    chk("arst/pc", pc, 32'h0);
    chk("arst/instr", Instruction, 32'h0);
    chk("arst/opc4", opcplus4, 32'h0);
    chk("arst/valid", {31'd0, instr_valid}, 32'd0);
    chk("arst/req", {31'd0, imem_req}, 32'd0);
    reset = 1'b1;
    lat = 1;
    step();
    chk("refetch/req", {31'd0, imem_req}, 32'd1);
    chk("refetch/addr", {18'd0, imem_addr}, 32'd0);
    wait_exec(reqs);
    chk("refetch/valid", {31'd0, instr_valid}, 32'd1);
    chk("refetch/instr", Instruction, 32'hA500_0000);
    chk("refetch/pc", pc, 32'h0);

    jr = 1'b1; reg_rs = 32'hFFFF_FFFF;
    advance(32'hFFFF_FFFC, "top");
    advance(32'h0, "wrap");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
